rll_key_loader: RTL and testbench

- Upstream stage for the RLL-locked combinational benchmarks.
- Receives the unlock key as a serial frame and checks its parity.
- Commits the key to a held parallel register that drives the locked netlist's keyIn_0_0..keyIn_0_(KEY_WIDTH-1) inputs.
- Repeated bad frames cause a sticky lockout that zeroes the key.

---
 rtl/rll_key_loader_if.sv | 29 ++
 rtl/rll_key_loader.sv | 137 +++++++++++++
 tb/tb_rll_key_loader.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rll_key_loader_if.sv
// Key loader bus: frame control, serial handshake and committed key.
// The loader itself takes the slave side.
interface rll_key_loader_if #(
  parameter int KEY_WIDTH = 16
);
  logic                 load_start;
  logic                 abort;
  logic                 sdi;
  logic                 sdi_valid;
  logic                 sdi_ready;
  logic [KEY_WIDTH-1:0] key_out;
  logic                 key_valid;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 lockout;

  modport master (
    output load_start, abort, sdi, sdi_valid,
    input  sdi_ready, key_out, key_valid,
    input  busy, done, err, lockout
  );

  modport slave (
    input  load_start, abort, sdi, sdi_valid,
    output sdi_ready, key_out, key_valid,
    output busy, done, err, lockout
  );
endinterface

// File: rtl/rll_key_loader.sv
// Serial RLL unlock-key loader with even-parity check and sticky lockout.
// Drives the keyIn_0_* inputs of a locked netlist through key_out.
module rll_key_loader #(
  parameter int KEY_WIDTH = 16,
  parameter int MAX_FAIL  = 3
) (
  input logic             clk,
  input logic             rst_n,
  rll_key_loader_if.slave bus
);
  localparam int CW = $clog2(KEY_WIDTH + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [CW-1:0] LAST = CW'(KEY_WIDTH);
  localparam logic [FW-1:0] FMAX = FW'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_CHECK, S_COMMIT, S_LOCK
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [KEY_WIDTH-1:0] r_staging;
  logic [KEY_WIDTH-1:0] r_key;
  logic [CW-1:0]        r_bit_cnt;
  logic [FW-1:0]        r_fail_cnt;
  logic                 r_par;
  logic                 r_key_valid;
  logic                 r_done;
  logic                 r_err;
  logic                 w_ready;
  logic                 w_busy;
  logic                 w_done_nxt;
  logic                 w_err_nxt;
  logic                 w_acc;
  logic                 w_last;
  logic [FW-1:0]        w_fail_inc;

  assign w_last = (r_bit_cnt == LAST);
  assign w_acc  = bus.sdi_valid && w_ready && !bus.abort;
  assign w_fail_inc = (r_fail_cnt == FMAX) ? r_fail_cnt
                    : r_fail_cnt + FW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.load_start) w_next = S_SHIFT;
      S_SHIFT: begin
        if (bus.abort)          w_next = S_IDLE;
        else if (w_acc && w_last) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (!r_par)                  w_next = S_COMMIT;
        else if (w_fail_inc == FMAX) w_next = S_LOCK;
        else                         w_next = S_IDLE;
      end
      S_COMMIT: w_next = S_IDLE;
      S_LOCK:   w_next = S_LOCK;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready    = 1'b0;
    w_busy     = 1'b0;
    w_done_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    unique case (r_state)
      S_SHIFT: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
      end
      S_CHECK: begin
        w_busy    = 1'b1;
        w_err_nxt = r_par;
      end
      S_COMMIT: begin
        w_busy     = 1'b1;
        w_done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // r_par holds the XOR of every accepted bit, so CHECK just tests it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_staging   <= '0;
      r_key       <= '0;
      r_bit_cnt   <= '0;
      r_fail_cnt  <= '0;
      r_par       <= 1'b0;
      r_key_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
      if (r_state == S_IDLE && bus.load_start) begin
        r_bit_cnt   <= '0;
        r_staging   <= '0;
        r_par       <= 1'b0;
        r_key_valid <= 1'b0;
      end
      if (w_acc) begin
        r_bit_cnt <= r_bit_cnt + CW'(1);
        r_par     <= r_par ^ bus.sdi;
        if (!w_last)
          r_staging <= {bus.sdi, r_staging[KEY_WIDTH-1:1]};
      end
      if (r_state == S_CHECK && r_par) begin
        r_fail_cnt <= w_fail_inc;
        if (w_fail_inc == FMAX) begin
          r_key       <= '0;
          r_key_valid <= 1'b0;
        end
      end
      if (r_state == S_COMMIT) begin
        r_key       <= r_staging;
        r_key_valid <= 1'b1;
        r_fail_cnt  <= '0;
      end
    end
  end

  assign bus.sdi_ready = w_ready;
  assign bus.busy      = w_busy;
  assign bus.key_out   = r_key;
  assign bus.key_valid = r_key_valid;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.lockout   = (r_state == S_LOCK);
endmodule

// File: tb/tb_rll_key_loader.sv
// Directed bench for rll_key_loader: framing, parity, abort,
// lockout and asynchronous reset.
module tb_rll_key_loader;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  rll_key_loader_if #(.KEY_WIDTH(16)) bus ();

  rll_key_loader #(
    .KEY_WIDTH(16),
    .MAX_FAIL (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] k, input logic p);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.sdi       = (i < 16) ? k[i] : p;
      bus.sdi_valid = 1'b1;
      tick();
    end
    bus.sdi_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.load_start = 1'b0;
    bus.abort      = 1'b0;
    bus.sdi        = 1'b0;
    bus.sdi_valid  = 1'b0;
    #12;
    n_cmp++;
    if ({bus.key_out, bus.key_valid, bus.sdi_ready, bus.busy,
         bus.done, bus.err, bus.lockout} !== 22'h0) begin
      n_bad++;
      $display("FAIL reset_outs: got key=%h kv=%b rdy=%b busy=%b",
               bus.key_out, bus.key_valid, bus.sdi_ready, bus.busy);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.sdi_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b rdy=%b want 0 0",
               bus.busy, bus.sdi_ready);
    end
  endtask

  task automatic test_good_frame();
    send_frame(16'hA5C3, 1'b0);
    n_cmp++;
    if (bus.key_valid !== 1'b0 || bus.key_out !== 16'h0000
        || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL good_edge0: kv=%b key=%h done=%b want 0 0000 0",
               bus.key_valid, bus.key_out, bus.done);
    end
    tick();
    n_cmp++;
    if (bus.key_valid !== 1'b0 || bus.done !== 1'b0
        || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL good_edge1: kv=%b done=%b busy=%b want 0 0 1",
               bus.key_valid, bus.done, bus.busy);
    end
    tick();
    n_cmp++;
    if (bus.key_out !== 16'hA5C3 || bus.key_valid !== 1'b1
        || bus.done !== 1'b1 || bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL good_commit: key=%h kv=%b done=%b err=%b want a5c3 1 1 0",
               bus.key_out, bus.key_valid, bus.done, bus.err);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL good_after: done=%b busy=%b want 0 0",
               bus.done, bus.busy);
    end
  endtask

  task automatic test_stall();
    logic [15:0] k;
    logic        stall_ok;
    k = 16'hA5C3;
    stall_ok = 1'b1;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.sdi_valid = 1'b0;
      tick();
      if (bus.sdi_ready !== 1'b1 || dut.r_bit_cnt !== 5'(i))
        stall_ok = 1'b0;
      bus.sdi       = (i < 16) ? k[i] : 1'b0;
      bus.sdi_valid = 1'b1;
      tick();
    end
    bus.sdi_valid = 1'b0;
    n_cmp++;
    if (stall_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_ready_cnt: got %b want 1", stall_ok);
    end
    n_cmp++;
    if (bus.key_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_kv_clear: got %b want 0", bus.key_valid);
    end
    tick();
    tick();
    n_cmp++;
    if (bus.key_out !== 16'hA5C3 || bus.key_valid !== 1'b1
        || bus.done !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_commit: key=%h kv=%b done=%b want a5c3 1 1",
               bus.key_out, bus.key_valid, bus.done);
    end
  endtask

  task automatic test_bad_then_good();
    send_frame(16'hA5C3, 1'b1);
    tick();
    n_cmp++;
    if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.key_valid !== 1'b0
        || bus.key_out !== 16'hA5C3 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_parity: err=%b done=%b kv=%b key=%h busy=%b",
               bus.err, bus.done, bus.key_valid, bus.key_out, bus.busy);
    end
    n_cmp++;
    if (dut.r_fail_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL bad_failcnt: got %0d want 1", dut.r_fail_cnt);
    end
    tick();
    n_cmp++;
    if (bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_err_pulse: got %b want 0", bus.err);
    end
    send_frame(16'h1234, 1'b1);
    tick();
    tick();
    n_cmp++;
    if (bus.key_out !== 16'h1234 || bus.key_valid !== 1'b1
        || bus.done !== 1'b1 || bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL regood_commit: key=%h kv=%b done=%b err=%b",
               bus.key_out, bus.key_valid, bus.done, bus.err);
    end
    n_cmp++;
    if (dut.r_fail_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL regood_failcnt: got %0d want 0", dut.r_fail_cnt);
    end
  endtask

  task automatic test_abort();
    logic [15:0] k;
    k = 16'h00FF;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.sdi       = k[i];
      bus.sdi_valid = 1'b1;
      tick();
    end
    bus.sdi       = 1'b1;
    bus.abort     = 1'b1;
    tick();
    bus.abort     = 1'b0;
    bus.sdi_valid = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.sdi_ready !== 1'b0
        || dut.r_bit_cnt !== 5'd7) begin
      n_bad++;
      $display("FAIL abort_idle: busy=%b rdy=%b cnt=%0d want 0 0 7",
               bus.busy, bus.sdi_ready, dut.r_bit_cnt);
    end
    n_cmp++;
    if (bus.key_out !== 16'h1234 || bus.key_valid !== 1'b0
        || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_key: key=%h kv=%b done=%b want 1234 0 0",
               bus.key_out, bus.key_valid, bus.done);
    end
    send_frame(16'h8001, 1'b0);
    tick();
    tick();
    n_cmp++;
    if (bus.key_out !== 16'h8001 || bus.key_valid !== 1'b1
        || bus.done !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_recommit: key=%h kv=%b done=%b want 8001 1 1",
               bus.key_out, bus.key_valid, bus.done);
    end
  endtask

  task automatic test_async_reset();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.sdi       = 1'b1;
      bus.sdi_valid = 1'b1;
      tick();
    end
    bus.sdi_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.sdi_ready !== 1'b0
        || bus.key_out !== 16'h0000 || bus.key_valid !== 1'b0
        || bus.lockout !== 1'b0 || dut.r_bit_cnt !== 5'd0) begin
      n_bad++;
      $display("FAIL async_reset: busy=%b rdy=%b key=%h kv=%b cnt=%0d",
               bus.busy, bus.sdi_ready, bus.key_out, bus.key_valid,
               dut.r_bit_cnt);
    end
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lockout();
    logic saw_done;
    logic saw_ready;
    send_frame(16'h1234, 1'b1);
    tick();
    tick();
    for (int f = 0; f < 3; f++) begin
      send_frame(16'h0F0F, 1'b1);
      tick();
      n_cmp++;
      if (bus.err !== 1'b1 || bus.lockout !== ((f == 2) ? 1'b1 : 1'b0)) begin
        n_bad++;
        $display("FAIL lock_bad%0d: err=%b lockout=%b", f, bus.err,
                 bus.lockout);
      end
      tick();
    end
    n_cmp++;
    if (bus.key_out !== 16'h0000 || bus.key_valid !== 1'b0
        || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_state: key=%h kv=%b busy=%b err=%b want 0 0 0 0",
               bus.key_out, bus.key_valid, bus.busy, bus.err);
    end
    saw_done  = 1'b0;
    saw_ready = 1'b0;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.sdi       = (i == 16) ? 1'b0 : 1'b1;
      bus.sdi_valid = 1'b1;
      if (bus.sdi_ready) saw_ready = 1'b1;
      if (bus.done) saw_done = 1'b1;
      tick();
    end
    bus.sdi_valid = 1'b0;
    n_cmp++;
    if (saw_ready !== 1'b0 || saw_done !== 1'b0 || bus.lockout !== 1'b1
        || bus.key_out !== 16'h0000) begin
      n_bad++;
      $display("FAIL lock_ignore: rdy=%b done=%b lockout=%b key=%h",
               saw_ready, saw_done, bus.lockout, bus.key_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.lockout !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_clear: got %b want 0", bus.lockout);
    end
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_good_frame();
    test_stall();
    test_bad_then_good();
    test_abort();
    test_async_reset();
    test_lockout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
